detector_jogada: RTL

- Input stage for the tic-tac-toe board; sits directly upstream of the 9-button to 1–9 binary converter.
- Takes the 9 raw, asynchronous push-button lines and synchronises and debounces them.
- Accepts one press per push-release cycle and drives a registered, held, one-hot `botoes` vector plus handshake pulses for the game control FSM.
- Multiple simultaneous presses are rejected, so the downstream converter only ever sees a clean one-hot value or zero.

---
 rtl/jogo_pkg.sv | 29 ++
 rtl/detector_jogada_sincronizador.sv | 36 +++
 rtl/detector_jogada.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// -----------------------------------------------------------------------------
// jogo_pkg
//   Shared definitions for the tic-tac-toe board input stage.
//   - NUM_BOTOES   : number of board buttons (cells 1..9).
//   - estado_t     : states of the press detector FSM.
//   - eh_one_hot() : true when exactly one bit of a button vector is set.
// -----------------------------------------------------------------------------
package jogo_pkg;

  localparam int NUM_BOTOES = 9;

  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,  // no button seen
    ESTABILIZANDO  = 2'd1,  // waiting for the pressed pattern to settle
    REGISTRA       = 2'd2,  // single decision cycle: accept, reject or discard
    AGUARDA_SOLTAR = 2'd3   // waiting for a debounced full release
  } estado_t;

  // Popcount == 1. A zero vector is not one-hot.
  function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      n = n + 32'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
//   Two-flop synchroniser for a bus of independent asynchronous levels.
//   Each bit is synchronised on its own; no cross-bit coherence is implied,
//   the downstream debouncer takes care of bits settling on different cycles.
// Ports:
//   clock   - system clock
//   reset   - synchronous active-high reset, clears both stages
//   entrada - raw asynchronous levels
//   sinc    - synchronised levels (second flop)
// -----------------------------------------------------------------------------
module sincronizador #(
  parameter int LARGURA = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] sinc
);

  logic [LARGURA-1:0] estagio1_q;
  logic [LARGURA-1:0] estagio2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estagio1_q <= '0;
      estagio2_q <= '0;
    end else begin
      estagio1_q <= entrada;
      estagio2_q <= estagio1_q;
    end
  end

  assign sinc = estagio2_q;

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
//   Input stage for the tic-tac-toe board. Synchronises and debounces the nine
//   push-buttons, accepts one press per push-release cycle and presents a held
//   one-hot move to the downstream 9-to-binary converter.
// Ports:
//   clock          - system clock, rising edge
//   reset          - synchronous active-high reset
//   botoes_entrada - raw active-high buttons, bit i = cell i+1 (asynchronous)
//   habilita       - control FSM is waiting for a move (sampled in REGISTRA)
//   limpa          - clears the held move at the next edge
//   botoes         - held one-hot move, zero when none
//   jogada_valida  - one-cycle pulse when a new move is loaded into botoes
//   erro_multiplo  - one-cycle pulse when a multi-button press is rejected
//   ocupado        - FSM is not idle
// Timing: with DEBOUNCE_CICLOS = N, a clean press sampled by the synchroniser
// at edge 0 shows up on botoes/jogada_valida after edge N+2.
// DEBOUNCE_CICLOS must be at least 2.
// -----------------------------------------------------------------------------
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int NUM_BOTOES      = jogo_pkg::NUM_BOTOES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BOTOES-1:0] botoes_entrada,
  input  logic                  habilita,
  input  logic                  limpa,
  output logic [NUM_BOTOES-1:0] botoes,
  output logic                  jogada_valida,
  output logic                  erro_multiplo,
  output logic                  ocupado
);

  // Counter only has to hold values up to DEBOUNCE_CICLOS-1.
  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CONT_ULTIMO = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CONT_UM     = CW'(1);

  logic [NUM_BOTOES-1:0] sinc;

  estado_t               estado_q;
  logic [CW-1:0]         contador_q;
  logic [NUM_BOTOES-1:0] candidato_q;
  logic [NUM_BOTOES-1:0] botoes_q;
  logic                  jogada_valida_q;
  logic                  erro_multiplo_q;
  logic                  ocupado_q;

  logic                  candidato_one_hot;

  sincronizador #(
    .LARGURA (NUM_BOTOES)
  ) u_sincronizador (
    .clock   (clock),
    .reset   (reset),
    .entrada (botoes_entrada),
    .sinc    (sinc)
  );

  assign candidato_one_hot = eh_one_hot(candidato_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      contador_q      <= '0;
      candidato_q     <= '0;
      botoes_q        <= '0;
      jogada_valida_q <= 1'b0;
      erro_multiplo_q <= 1'b0;
      ocupado_q       <= 1'b0;
    end else begin
      // Pulses are single-cycle by default.
      jogada_valida_q <= 1'b0;
      erro_multiplo_q <= 1'b0;

      // A capture in REGISTRA below overrides this clear, so a move
      // arriving in the same cycle as limpa is not lost.
      if (limpa) begin
        botoes_q <= '0;
      end

      case (estado_q)
        OCIOSO: begin
          if (sinc != '0) begin
            candidato_q <= sinc;
            contador_q  <= CONT_UM;
            estado_q    <= ESTABILIZANDO;
            ocupado_q   <= 1'b1;
          end
        end

        ESTABILIZANDO: begin
          if (sinc == '0) begin
            // Released before settling: treat as noise.
            contador_q <= '0;
            estado_q   <= OCIOSO;
            ocupado_q  <= 1'b0;
          end else if (sinc != candidato_q) begin
            // Pattern changed (bounce or another finger): restart the count
            // on the new pattern.
            candidato_q <= sinc;
            contador_q  <= CONT_UM;
          end else if (contador_q == CONT_ULTIMO) begin
            estado_q <= REGISTRA;
          end else begin
            contador_q <= contador_q + CONT_UM;
          end
        end

        REGISTRA: begin
          if (habilita) begin
            if (candidato_one_hot) begin
              botoes_q        <= candidato_q;
              jogada_valida_q <= 1'b1;
            end else begin
              // candidato is never zero here, so not one-hot means 2+ bits.
              erro_multiplo_q <= 1'b1;
            end
          end
          contador_q <= '0;
          estado_q   <= AGUARDA_SOLTAR;
        end

        AGUARDA_SOLTAR: begin
          // Any button activity, including extra presses, restarts the
          // release count; nothing is captured until we are idle again.
          if (sinc != '0) begin
            contador_q <= '0;
          end else if (contador_q == CONT_ULTIMO) begin
            contador_q <= '0;
            estado_q   <= OCIOSO;
            ocupado_q  <= 1'b0;
          end else begin
            contador_q <= contador_q + CONT_UM;
          end
        end

        default: begin
          contador_q <= '0;
          estado_q   <= OCIOSO;
          ocupado_q  <= 1'b0;
        end
      endcase
    end
  end

  assign botoes        = botoes_q;
  assign jogada_valida = jogada_valida_q;
  assign erro_multiplo = erro_multiplo_q;
  assign ocupado       = ocupado_q;

endmodule
